// File: rtl/alu_serial_2bit_if.sv
// Request/response bundle for alu_serial_2bit.
// Start is taken only when busy is low; done is a one-cycle pulse and r/co/v/z hold until the next done.
interface alu_serial_2bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       s;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             co;
    logic             v;
    logic             z;

    modport master (
        output start, a, b, s, ci,
        input  busy, done, r, co, v, z
    );

    modport slave (
        input  start, a, b, s, ci,
        output busy, done, r, co, v, z
    );
endinterface

// File: rtl/alu_serial_2bit.sv
// Bit-serial ALU: one 2-bit slice (ADD/XOR/AND/pass-A) per clock, LSB first, registered carry.
// Optional macro ALU_SERIAL_FAST_LOGIC_EN: non-ADD ops finish in a single RUN cycle.
module alu_serial_2bit #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_serial_2bit_if.slave    bus,
    output logic [1:0]          state_dbg
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;

    logic             c1;
    logic             c2;
    logic [1:0]       slice;
    logic [WIDTH-1:0] slice_ext;
    logic [WIDTH-1:0] acc_next;
    logic             last;
    logic             is_add;

    // Operands shift right so the active slice always sits at bit [1:0];
    // results enter at the top of acc and walk down to their final position.
    always_comb begin
        c1        = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        c2        = (a_sh[1] & b_sh[1]) | (c1 & (a_sh[1] ^ b_sh[1]));
        is_add    = (op == 2'b00);
        last      = (cnt == CW'(N - 1));
        slice     = 2'b00;
        case (op)
            2'b00:   slice = {a_sh[1] ^ b_sh[1] ^ c1, a_sh[0] ^ b_sh[0] ^ carry};
            2'b01:   slice = a_sh[1:0] ^ b_sh[1:0];
            2'b10:   slice = a_sh[1:0] & b_sh[1:0];
            default: slice = a_sh[1:0];
        endcase
        slice_ext = WIDTH'(slice);
        acc_next  = (acc >> 2) | (slice_ext << (WIDTH - 2));
    end

`ifdef ALU_SERIAL_FAST_LOGIC_EN
    logic [WIDTH-1:0] logic_res;

    always_comb begin
        logic_res = a_sh;
        case (op)
            2'b01:   logic_res = a_sh ^ b_sh;
            2'b10:   logic_res = a_sh & b_sh;
            default: logic_res = a_sh;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            op     <= 2'b00;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            bus.r  <= '0;
            bus.co <= 1'b0;
            bus.v  <= 1'b0;
            bus.z  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        op    <= bus.s;
                        carry <= bus.ci;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef ALU_SERIAL_FAST_LOGIC_EN
                    if (!is_add) begin
                        acc    <= logic_res;
                        bus.r  <= logic_res;
                        bus.co <= 1'b0;
                        bus.v  <= 1'b0;
                        bus.z  <= (logic_res == '0);
                        state  <= DONE_ST;
                    end else
`endif
                    begin
                        a_sh  <= a_sh >> 2;
                        b_sh  <= b_sh >> 2;
                        acc   <= acc_next;
                        carry <= is_add ? c2 : 1'b0;
                        cnt   <= cnt + CW'(1);
                        // c1 of the last slice is the carry into bit WIDTH-1
                        if (last) begin
                            bus.r  <= acc_next;
                            bus.co <= is_add & c2;
                            bus.v  <= is_add & (c1 ^ c2);
                            bus.z  <= (acc_next == '0);
                            cnt    <= '0;
                            state  <= DONE_ST;
                        end
                    end
                end
                DONE_ST: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE_ST);
    assign state_dbg = state;
endmodule

// File: tb/tb_alu_serial_2bit.sv
// Scoreboard bench for alu_serial_2bit: driver pushes model results, monitor pops on done.
// Honors ALU_SERIAL_FAST_LOGIC_EN for expected latency.
module tb_alu_serial_2bit;
    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;
    localparam int EW    = 32 + 3 + WIDTH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  state_dbg;
    int          n_chk  = 0;
    int          n_pass = 0;
    int unsigned cyc    = 0;
    logic [EW-1:0] exp_q[$];

    alu_serial_2bit_if #(.WIDTH(WIDTH)) bus();

    alu_serial_2bit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    function automatic int op_lat(input logic [1:0] s);
`ifdef ALU_SERIAL_FAST_LOGIC_EN
        if (s != 2'b00) return 1;
`endif
        return N;
    endfunction

    // Reference: whole-word arithmetic, V from operand/result sign rule.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [1:0] s, input logic ci, input int unsigned due);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        logic             co, v;
        co = 1'b0;
        v  = 1'b0;
        case (s)
            2'b00: begin
                sum = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(ci);
                r   = sum[WIDTH-1:0];
                co  = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            2'b01:   r = a ^ b;
            2'b10:   r = a & b;
            default: r = a;
        endcase
        return {due, (r == '0), v, co, r};
    endfunction

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] s, input logic ci);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) chk("issue_wait_idle", {63'b0, bus.busy}, 64'd0);
        bus.a     = a;
        bus.b     = b;
        bus.s     = s;
        bus.ci    = ci;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(a, b, s, ci, cyc + op_lat(s)));
        bus.start = 1'b0;
        chk("busy_after_accept", {63'b0, bus.busy}, 64'd1);
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, {63'b0, bus.busy}, 64'd0);
        chk({tag, "_done"}, {63'b0, bus.done}, 64'd0);
        chk({tag, "_r"},    64'(bus.r),        64'd0);
        chk({tag, "_flags"}, {61'b0, bus.co, bus.v, bus.z}, 64'd0);
    endtask

    // Monitor: compares on done, otherwise checks outputs hold their last value.
    initial begin
        logic          prev_done;
        logic [WIDTH+2:0] held;
        logic [EW-1:0] e;
        prev_done = 1'b0;
        held      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                held      = '0;
                prev_done = 1'b0;
            end else begin
                if (bus.done === 1'b1) begin
                    chk("done_single_cycle", {63'b0, prev_done}, 64'd0);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_done actual=done_high required=done_low cyc=%0d", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("r",  64'(bus.r),  64'(e[WIDTH-1:0]));
                        chk("co", {63'b0, bus.co}, {63'b0, e[WIDTH]});
                        chk("v",  {63'b0, bus.v},  {63'b0, e[WIDTH+1]});
                        chk("z",  {63'b0, bus.z},  {63'b0, e[WIDTH+2]});
                        chk("done_cycle", 64'(cyc), 64'(e[EW-1:WIDTH+3]));
                        held = e[WIDTH+2:0];
                    end
                end else begin
                    chk("hold_outputs", 64'({bus.z, bus.v, bus.co, bus.r}), 64'(held));
                end
                prev_done = bus.done;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.s     = 2'b00;
        bus.ci    = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        chk("reset_state", 64'(state_dbg), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_outputs("post_release");

        issue(8'hFF, 8'h01, 2'b00, 1'b0);
        issue(8'h7F, 8'h00, 2'b00, 1'b1);
        issue(8'h80, 8'h80, 2'b00, 1'b0);
        issue(8'hA5, 8'h5A, 2'b01, 1'b0);
        issue(8'hF0, 8'h0F, 2'b10, 1'b1);

        // Pass-A with start held high through RUN and DONE: must be ignored.
        issue(8'h3C, 8'hFF, 2'b11, 1'b0);
        bus.start = 1'b1;
        for (int k = 0; k < op_lat(2'b11) + 1; k++) begin
            bus.a = WIDTH'($urandom);
            bus.b = WIDTH'($urandom);
            bus.s = 2'($urandom_range(0, 3));
            @(posedge clk);
        end
        #1;
        bus.start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);

        // Reset during the second RUN cycle of an ADD aborts it.
        issue(8'h55, 8'h33, 2'b00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_zero_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 3) @(negedge clk);
        chk_zero_outputs("after_abort");
        issue(8'h01, 8'h01, 2'b00, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '1;
            if ($urandom_range(0, 7) == 0) rb = ~ra;
            issue(ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        wait_drain();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_serial_2bit.md
# alu_serial_2bit

Bit-serial multi-cycle ALU that processes a WIDTH-bit operation two bits per clock, LSB slice first, using the same 2-bit slice function set as the combinational ALU slice (ADD, XOR, AND, pass-A) with a registered carry between slices. It sits between a requester that issues one operation at a time via a Start/Busy/Done handshake and downstream logic that consumes the registered result and flags. Area is traded for latency: one 2-bit slice datapath serves any even WIDTH.

## Interface
- WIDTH, 8, operand/result width; must be even and >= 2; N = WIDTH/2 slices.
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only when Busy=0.
- A  input  WIDTH  operand A; latched on Start acceptance.
- B  input  WIDTH  operand B; latched on Start acceptance.
- S  input  2  op select: 00 ADD, 01 XOR, 10 AND, 11 pass A; latched.
- Ci  input  1  carry-in for ADD; latched, ignored for other ops.
- Busy  output  1  high from Start acceptance until Done cycle ends.
- Done  output  1  one-cycle pulse; R/Co/V/Z valid from this cycle.
- R  output  WIDTH  registered result.
- Co  output  1  carry out of MSB slice (ADD only, else 0).
- V  output  1  signed overflow = carry into MSB xor carry out of MSB (ADD only, else 0).
- Z  output  1  1 when R == 0, all ops.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: Busy=0, Done=0. Start=1 at an edge -> latch A, B, S, Ci; slice counter=0; carry reg=Ci; go RUN.
- RUN: each edge computes slice k = bits [2k+1:2k] from latched operands and carry reg, writes into internal result register, updates carry reg, records carry into bit WIDTH-1 for V. At k = N-1 -> load R, Co, V, Z and go DONE.
- DONE: Done=1, Busy=1 for one cycle, then IDLE unconditionally.
- Start while Busy=1 (RUN or DONE) ignored, not queued.
- R/Co/V/Z change only on the edge entering DONE; held through IDLE until next DONE entry.
- ADD is modulo 2^WIDTH; Co and V as defined above. Logic ops and pass force Co=0, V=0.
- Reset: async to IDLE; Busy=0, Done=0, R=0, Co=0, V=0, Z=0; counter, carry and latched operands cleared. Reset mid-RUN aborts the operation; no Done pulse follows release.

## Timing
- Start sampled at edge E0. RUN edges E1..EN. Done high in the cycle after edge EN (N cycles after E0); Busy high from E0 through edge EN+1.
- Throughput: one operation per N+2 cycles (IDLE cycle needed to re-accept).
- No combinational path from inputs to outputs.
- WIDTH=2: N=1, Done in cycle after E1.

## Configuration
- ALU_SERIAL_FAST_LOGIC_EN defined: for S != 00 all slices are computed in parallel on edge E1, go directly RUN -> DONE; Done high in cycle after E1 regardless of WIDTH. ADD unchanged (N cycles).
- Not defined: every op takes N RUN cycles.

## Test plan
- Reset: hold Rst_n=0 -> Busy=0, Done=0, R=0, Co=V=Z=0; release, outputs unchanged with Start=0.
- WIDTH=8 ADD A=8'hFF B=8'h01 Ci=0 -> R=8'h00, Co=1, V=0, Z=1; Done exactly 4 cycles after accepting edge, single cycle wide.
- ADD A=8'h7F B=8'h00 Ci=1 -> R=8'h80, Co=0, V=1, Z=0; ADD A=8'h80 B=8'h80 -> R=8'h00, Co=1, V=1, Z=1.
- XOR A=8'hA5 B=8'h5A -> R=8'hFF, Z=0, Co=V=0; AND A=8'hF0 B=8'h0F -> R=8'h00, Z=1; Done at 4 cycles, or 1 cycle with ALU_SERIAL_FAST_LOGIC_EN.
- Pass S=11 A=8'h3C B=8'hFF -> R=8'h3C; second Start pulsed during RUN and DONE ignored (exactly one Done, R unchanged until next accepted Start).
- Rst_n low for one cycle during second RUN cycle of an ADD -> Busy=0, outputs 0, no Done afterwards; next Start ADD A=8'h01 B=8'h01 Ci=0 -> R=8'h02.
